// File: rtl/bht_predictor.sv
// Branch history table: per-entry saturating counters indexed by PC (optionally
// hashed with a resolution-time global history), plus resolved-branch statistics.
module bht_predictor #(
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned HIST_W  = 0,
  parameter int unsigned STAT_W  = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               pred_valid_i,
  input  logic [31:0]        pred_pc_i,
  input  logic [31:0]        pred_offset_i,
  output logic               pred_taken_o,
  output logic [31:0]        pred_target_o,
  output logic [INDEX_W-1:0] pred_idx_o,
  input  logic               upd_valid_i,
  input  logic [INDEX_W-1:0] upd_idx_i,
  input  logic               upd_taken_i,
  input  logic               upd_mispredict_i,
  output logic [STAT_W-1:0]  stat_branches_o,
  output logic [STAT_W-1:0]  stat_mispredicts_o
);

  localparam int unsigned DEPTH = 1 << INDEX_W;
  // History register keeps one dummy bit in bimodal mode so it always has a legal width.
  localparam int unsigned GHR_W = (HIST_W > 0) ? HIST_W : 1;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);

  logic [CTR_W-1:0]   ctr [DEPTH];
  logic [GHR_W-1:0]   ghr;
  logic [INDEX_W-1:0] hist_ext;
  logic [INDEX_W-1:0] idx;
  logic               unused_pc_bits;

  assign unused_pc_bits = ^{pred_pc_i[1:0], pred_pc_i[31:INDEX_W+2]};

  always_comb begin
    hist_ext = '0;
    if (HIST_W > 0) hist_ext[GHR_W-1:0] = ghr;
  end

  assign idx           = pred_pc_i[INDEX_W+1:2] ^ hist_ext;
  assign pred_idx_o    = idx;
  assign pred_taken_o  = pred_valid_i & ctr[idx][CTR_W-1];
  assign pred_target_o = pred_pc_i + pred_offset_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) ctr[i[INDEX_W-1:0]] <= CTR_INIT;
      ghr                <= '0;
      stat_branches_o    <= '0;
      stat_mispredicts_o <= '0;
    end else if (upd_valid_i) begin
      if (upd_taken_i) begin
        if (ctr[upd_idx_i] != '1) ctr[upd_idx_i] <= ctr[upd_idx_i] + CTR_W'(1);
      end else begin
        if (ctr[upd_idx_i] != '0) ctr[upd_idx_i] <= ctr[upd_idx_i] - CTR_W'(1);
      end
      // Oldest outcome falls off the top when the concatenation is truncated.
      if (HIST_W > 0) ghr <= GHR_W'({ghr, upd_taken_i});
      if (stat_branches_o != '1) stat_branches_o <= stat_branches_o + STAT_W'(1);
      if (upd_mispredict_i && (stat_mispredicts_o != '1))
        stat_mispredicts_o <= stat_mispredicts_o + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_bht_predictor.sv
// Directed bench for bht_predictor: bimodal defaults, HIST_W=2 and STAT_W=4
// instances share one stimulus set; each scenario checks the instance it targets.
module tb_bht_predictor;

  logic        clk;
  logic        reset;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic [31:0] pred_offset;
  logic        upd_valid;
  logic [5:0]  upd_idx;
  logic        upd_taken;
  logic        upd_mispredict;

  logic        d_taken, h_taken, s_taken;
  logic [31:0] d_target, h_target, s_target;
  logic [5:0]  d_idx, h_idx, s_idx;
  logic [31:0] d_branches, d_mis, h_branches, h_mis;
  logic [3:0]  s_branches, s_mis;

  int vectors = 0;
  int miscompares = 0;

  bht_predictor u_def (
    .clk_i(clk), .reset_i(reset), .pred_valid_i(pred_valid), .pred_pc_i(pred_pc),
    .pred_offset_i(pred_offset), .pred_taken_o(d_taken), .pred_target_o(d_target),
    .pred_idx_o(d_idx), .upd_valid_i(upd_valid), .upd_idx_i(upd_idx),
    .upd_taken_i(upd_taken), .upd_mispredict_i(upd_mispredict),
    .stat_branches_o(d_branches), .stat_mispredicts_o(d_mis)
  );

  bht_predictor #(.HIST_W(2)) u_hist (
    .clk_i(clk), .reset_i(reset), .pred_valid_i(pred_valid), .pred_pc_i(pred_pc),
    .pred_offset_i(pred_offset), .pred_taken_o(h_taken), .pred_target_o(h_target),
    .pred_idx_o(h_idx), .upd_valid_i(upd_valid), .upd_idx_i(upd_idx),
    .upd_taken_i(upd_taken), .upd_mispredict_i(upd_mispredict),
    .stat_branches_o(h_branches), .stat_mispredicts_o(h_mis)
  );

  bht_predictor #(.STAT_W(4)) u_stat (
    .clk_i(clk), .reset_i(reset), .pred_valid_i(pred_valid), .pred_pc_i(pred_pc),
    .pred_offset_i(pred_offset), .pred_taken_o(s_taken), .pred_target_o(s_target),
    .pred_idx_o(s_idx), .upd_valid_i(upd_valid), .upd_idx_i(upd_idx),
    .upd_taken_i(upd_taken), .upd_mispredict_i(upd_mispredict),
    .stat_branches_o(s_branches), .stat_mispredicts_o(s_mis)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [5:0] idx, input logic taken, input logic mis);
    upd_valid = 1'b1;
    upd_idx = idx;
    upd_taken = taken;
    upd_mispredict = mis;
    tick();
    upd_valid = 1'b0;
    upd_taken = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_pred(input logic valid, input logic [31:0] pc, input logic [31:0] off);
    pred_valid = valid;
    pred_pc = pc;
    pred_offset = off;
    #1;
  endtask

  // Reset asserted together with an update: the update must be dropped.
  task automatic test_reset();
    reset = 1'b1;
    upd_valid = 1'b1; upd_idx = 6'd0; upd_taken = 1'b1; upd_mispredict = 1'b1;
    tick();
    reset = 1'b0;
    upd_valid = 1'b0; upd_taken = 1'b0; upd_mispredict = 1'b0;
    #1;
    vectors++;
    if (d_branches !== 32'd0) begin
      miscompares++; $display("FAIL reset_branches: got %0d want 0", d_branches);
    end
    vectors++;
    if (d_mis !== 32'd0) begin
      miscompares++; $display("FAIL reset_mispredicts: got %0d want 0", d_mis);
    end
    set_pred(1'b1, 32'h100, 32'h0);
    vectors++;
    if (d_taken !== 1'b0 || h_taken !== 1'b0) begin
      miscompares++; $display("FAIL reset_taken_0x100: got %b/%b want 0/0", d_taken, h_taken);
    end
    set_pred(1'b1, 32'h1FC, 32'h0);
    vectors++;
    if (d_taken !== 1'b0) begin
      miscompares++; $display("FAIL reset_taken_0x1fc: got %b want 0", d_taken);
    end
    // Weakly-not-taken init: one taken update flips the prediction.
    upd(6'd5, 1'b1, 1'b0);
    set_pred(1'b1, 32'h14, 32'h0);
    vectors++;
    if (d_taken !== 1'b1) begin
      miscompares++; $display("FAIL reset_init_weak: got %b want 1", d_taken);
    end
    vectors++;
    if (d_branches !== 32'd1) begin
      miscompares++; $display("FAIL reset_first_count: got %0d want 1", d_branches);
    end
  endtask

  task automatic test_prediction();
    set_pred(1'b1, 32'h100, 32'h20);
    vectors++;
    if (d_taken !== 1'b0 || d_target !== 32'h120 || d_idx !== 6'd0) begin
      miscompares++;
      $display("FAIL pred_basic: got taken=%b target=%h idx=%0d want 0/00000120/0", d_taken, d_target, d_idx);
    end
    set_pred(1'b0, 32'h14, 32'h20);
    vectors++;
    if (d_taken !== 1'b0 || d_target !== 32'h34 || d_idx !== 6'd5) begin
      miscompares++;
      $display("FAIL pred_invalid: got taken=%b target=%h idx=%0d want 0/00000034/5", d_taken, d_target, d_idx);
    end
    set_pred(1'b1, 32'h14, 32'h20);
    vectors++;
    if (d_taken !== 1'b1) begin
      miscompares++; $display("FAIL pred_valid_taken: got %b want 1", d_taken);
    end
    set_pred(1'b1, 32'hFFFF_FFF0, 32'h20);
    vectors++;
    if (d_target !== 32'h10 || d_idx !== 6'd60) begin
      miscompares++; $display("FAIL pred_wrap: got target=%h idx=%0d want 00000010/60", d_target, d_idx);
    end
    set_pred(1'b1, 32'h1000, 32'hFFFF_FFF0);
    vectors++;
    if (d_target !== 32'hFF0 || d_idx !== 6'd0) begin
      miscompares++; $display("FAIL pred_neg_off: got target=%h idx=%0d want 00000ff0/0", d_target, d_idx);
    end
  endtask

  task automatic test_counter();
    do_reset();
    set_pred(1'b1, 32'h100, 32'h0);
    upd(6'd0, 1'b1, 1'b0);
    vectors++;
    if (d_taken !== 1'b1) begin
      miscompares++; $display("FAIL ctr_first_taken: got %b want 1", d_taken);
    end
    for (int i = 0; i < 3; i++) upd(6'd0, 1'b1, 1'b0);
    upd(6'd0, 1'b0, 1'b0);
    vectors++;
    if (d_taken !== 1'b1) begin
      miscompares++; $display("FAIL ctr_sat_high: got %b want 1", d_taken);
    end
    upd(6'd0, 1'b0, 1'b0);
    vectors++;
    if (d_taken !== 1'b0) begin
      miscompares++; $display("FAIL ctr_step_down: got %b want 0", d_taken);
    end
    for (int i = 0; i < 3; i++) upd(6'd2, 1'b0, 1'b0);
    upd(6'd2, 1'b1, 1'b0);
    upd(6'd2, 1'b1, 1'b0);
    set_pred(1'b1, 32'h108, 32'h0);
    vectors++;
    if (d_taken !== 1'b1) begin
      miscompares++; $display("FAIL ctr_sat_low: got %b want 1", d_taken);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_pred(1'b1, 32'h104, 32'h0);
    upd_valid = 1'b1; upd_idx = 6'd1; upd_taken = 1'b1; upd_mispredict = 1'b0;
    #1;
    vectors++;
    if (d_taken !== 1'b0) begin
      miscompares++; $display("FAIL rbw_same_cycle: got %b want 0", d_taken);
    end
    tick();
    upd_valid = 1'b0; upd_taken = 1'b0;
    #1;
    vectors++;
    if (d_taken !== 1'b1) begin
      miscompares++; $display("FAIL rbw_next_cycle: got %b want 1", d_taken);
    end
  endtask

  task automatic test_ignore();
    do_reset();
    upd_valid = 1'b0; upd_idx = 6'd3; upd_taken = 1'b1; upd_mispredict = 1'b1;
    tick(); tick(); tick();
    set_pred(1'b1, 32'h10C, 32'h0);
    vectors++;
    if (d_taken !== 1'b0 || d_branches !== 32'd0 || d_mis !== 32'd0) begin
      miscompares++;
      $display("FAIL ignore_invalid_upd: got taken=%b br=%0d mis=%0d want 0/0/0", d_taken, d_branches, d_mis);
    end
    upd_taken = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic test_history();
    do_reset();
    set_pred(1'b1, 32'h100, 32'h0);
    upd_valid = 1'b1; upd_idx = 6'd0; upd_taken = 1'b1; upd_mispredict = 1'b0;
    #1;
    vectors++;
    if (h_idx !== 6'd0) begin
      miscompares++; $display("FAIL hist_idx_initial: got %0d want 0", h_idx);
    end
    tick();
    vectors++;
    if (h_idx !== 6'd1) begin
      miscompares++; $display("FAIL hist_idx_one: got %0d want 1", h_idx);
    end
    tick();
    upd_valid = 1'b0; upd_taken = 1'b0;
    #1;
    vectors++;
    if (h_idx !== 6'd3 || d_idx !== 6'd0 || h_taken !== 1'b0) begin
      miscompares++;
      $display("FAIL hist_idx_two: got h_idx=%0d d_idx=%0d h_taken=%b want 3/0/0", h_idx, d_idx, h_taken);
    end
    set_pred(1'b1, 32'h10C, 32'h0);
    vectors++;
    if (h_idx !== 6'd0 || h_taken !== 1'b1) begin
      miscompares++; $display("FAIL hist_hashed_hit: got idx=%0d taken=%b want 0/1", h_idx, h_taken);
    end
    upd(6'd0, 1'b0, 1'b0);
    set_pred(1'b1, 32'h100, 32'h0);
    vectors++;
    if (h_idx !== 6'd2) begin
      miscompares++; $display("FAIL hist_shift_out: got %0d want 2", h_idx);
    end
  endtask

  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      upd(6'(i), 1'b0, (i % 2) == 0);
      if (i == 13) begin
        vectors++;
        if (s_branches !== 4'd14) begin
          miscompares++; $display("FAIL stat_count_14: got %0d want 14", s_branches);
        end
      end
    end
    vectors++;
    if (s_branches !== 4'd15 || s_mis !== 4'd10) begin
      miscompares++; $display("FAIL stat_saturate: got br=%0d mis=%0d want 15/10", s_branches, s_mis);
    end
    vectors++;
    if (d_branches !== 32'd20 || d_mis !== 32'd10) begin
      miscompares++; $display("FAIL stat_wide: got br=%0d mis=%0d want 20/10", d_branches, d_mis);
    end
  endtask

  task automatic test_reset_priority();
    upd(6'd0, 1'b1, 1'b0);
    upd(6'd0, 1'b1, 1'b0);
    set_pred(1'b1, 32'h100, 32'h0);
    vectors++;
    if (d_taken !== 1'b1 || h_idx !== 6'd3) begin
      miscompares++; $display("FAIL prio_trained: got taken=%b h_idx=%0d want 1/3", d_taken, h_idx);
    end
    reset = 1'b1;
    upd_valid = 1'b1; upd_idx = 6'd0; upd_taken = 1'b1; upd_mispredict = 1'b1;
    tick();
    reset = 1'b0;
    upd_valid = 1'b0; upd_taken = 1'b0; upd_mispredict = 1'b0;
    #1;
    vectors++;
    if (d_taken !== 1'b0 || h_idx !== 6'd0) begin
      miscompares++; $display("FAIL prio_table: got taken=%b h_idx=%0d want 0/0", d_taken, h_idx);
    end
    vectors++;
    if (s_branches !== 4'd0 || s_mis !== 4'd0 || d_branches !== 32'd0) begin
      miscompares++;
      $display("FAIL prio_stats: got s_br=%0d s_mis=%0d d_br=%0d want 0/0/0", s_branches, s_mis, d_branches);
    end
  endtask

  initial begin
    reset = 1'b1;
    pred_valid = 1'b0;
    pred_pc = '0;
    pred_offset = '0;
    upd_valid = 1'b0;
    upd_idx = '0;
    upd_taken = 1'b0;
    upd_mispredict = 1'b0;
    test_reset();
    test_prediction();
    test_counter();
    test_back_to_back();
    test_ignore();
    test_history();
    test_stats();
    test_reset_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bht_predictor.md
BHT_PREDICTOR -- requirements
Module: bht_predictor

Interface
REQ-001 SHALL have parameter INDEX_W, default 6: table has 2^INDEX_W entries; legal range 2..12.
REQ-002 SHALL have parameter CTR_W, default 2: saturating counter width; legal range 1..4.
REQ-003 SHALL have parameter HIST_W, default 0: global history length; 0 selects bimodal mode; legal range 0..INDEX_W.
REQ-004 SHALL have parameter STAT_W, default 32: width of each statistics counter.
REQ-005 SHALL have port clk_i, input, 1: the only clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_i, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port pred_valid_i, input, 1: a conditional branch is in decode this cycle.
REQ-008 SHALL have port pred_pc_i, input, 32: PC of the decoded branch.
REQ-009 SHALL have port pred_offset_i, input, 32: sign-extended branch immediate.
REQ-010 SHALL have port pred_taken_o, output, 1: predict taken.
REQ-011 SHALL have port pred_target_o, output, 32: predicted target address.
REQ-012 SHALL have port pred_idx_o, output, INDEX_W: table index used; the pipeline carries it to resolution.
REQ-013 SHALL have port upd_valid_i, input, 1: a conditional branch resolves this cycle (MEM stage).
REQ-014 SHALL have port upd_idx_i, input, INDEX_W: index the branch was predicted with.
REQ-015 SHALL have port upd_taken_i, input, 1: actual branch outcome.
REQ-016 SHALL have port upd_mispredict_i, input, 1: prediction was wrong; valid only with upd_valid_i.
REQ-017 SHALL have port stat_branches_o, output, STAT_W: count of resolved branches.
REQ-018 SHALL have port stat_mispredicts_o, output, STAT_W: count of mispredictions.

Function
REQ-019 SHALL compute the index combinationally as pred_pc_i[INDEX_W+1:2] XOR {zero-extend, ghr[HIST_W-1:0]} when HIST_W>0, and as pred_pc_i[INDEX_W+1:2] only when HIST_W=0.
REQ-020 SHALL have zero-cycle prediction latency: pred_taken_o = pred_valid_i AND the MSB of ctr[idx], combinational in the same cycle.
REQ-021 SHALL compute pred_target_o = pred_pc_i + pred_offset_i modulo 2^32, independent of pred_valid_i.
REQ-022 SHALL drive pred_idx_o with the computed index at all times, independent of pred_valid_i.
REQ-023 SHALL, on an upd_valid_i cycle, increment ctr[upd_idx_i] when upd_taken_i=1 (saturating at 2^CTR_W-1) and decrement it otherwise (saturating at 0); the new value is visible from the next cycle.
REQ-024 SHALL, on an upd_valid_i cycle with HIST_W>0, shift ghr left by one and insert upd_taken_i at bit 0; ghr is non-speculative and updated only at resolution.
REQ-025 SHALL be read-before-write when prediction and update hit the same index in the same cycle: the prediction uses the pre-update counter and pre-shift ghr.
REQ-026 SHALL, on an upd_valid_i cycle, increment stat_branches_o, and also increment stat_mispredicts_o when upd_mispredict_i=1; both counters saturate at 2^STAT_W-1 and never wrap.
REQ-027 SHALL ignore upd_taken_i, upd_idx_i and upd_mispredict_i when upd_valid_i=0.
REQ-028 SHALL, when upd_valid_i=1 during reset_i, have reset take priority: no counter, ghr or stat update.

Reset
REQ-029 SHALL, while reset_i=1 at a clock edge, set every ctr entry to weakly-not-taken (2^(CTR_W-1)-1; 0 when CTR_W=1), ghr to 0, and both stat counters to 0.
REQ-030 SHALL, after reset, have pred_taken_o=0 for every PC until an update makes an entry taken.
REQ-031 SHALL complete reset in the single reset cycle; no multi-cycle table-clear state is required.

Verification
REQ-032 SHALL cover this scenario (defaults): reset; pred_valid_i=1, pc=0x100, off=0x20 -> taken_o=0, target_o=0x120, idx_o=0.
REQ-033 SHALL cover this scenario: one update idx=0, taken=1 -> next cycle pc=0x100 predicts taken; a further 3 taken updates leave ctr=3; 1 not-taken update gives ctr=2, still taken.
REQ-034 SHALL cover this scenario: same cycle pred pc=0x104 and update idx=1, taken=1 from reset -> taken_o=0 that cycle and taken_o=1 the next cycle.
REQ-035 SHALL cover this scenario (HIST_W=2): updates taken,taken -> ghr=2'b11; pc=0x100 gives idx_o=3.
REQ-036 SHALL cover this scenario (STAT_W=4): 20 updates with mispredict on the even ones -> branches=15 (saturated), mispredicts=10.
REQ-037 SHALL cover this scenario: reset_i=1 together with upd_valid_i=1 -> all ctr=1 and stats=0 the next cycle.
